// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises host words LSB-first into a DFF config chain and returns the displaced bits as readback words
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic [CNT_W-1:0]  bits_left
);
    localparam int KW = $clog2(WORD_W + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]        state;
    logic [WORD_W-1:0] shreg, cap, cap_nxt;
    logic [KW-1:0]     nbits, k;
    logic              rd_hs, cfg_hs, last_bit;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    // abort masks the chain clock and the input handshake in the same cycle it is taken
    assign prog_clk_en = state == SHIFT && !abort;
    assign cfg_ready   = state == FETCH && !abort && (!rd_valid || rd_ready);
    assign ccff_head   = state == SHIFT && shreg[0];
    assign rd_hs       = rd_valid && rd_ready;
    assign cfg_hs      = cfg_valid && cfg_ready;
    assign last_bit    = k == nbits - KW'(1);
    assign cap_nxt     = cap | (WORD_W'(ccff_tail) << k);
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cap       <= '0;
            nbits     <= '0;
            k         <= '0;
            bits_left <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (rd_hs) rd_valid <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                rd_valid  <= 1'b0;
                aborted   <= 1'b1;
                bits_left <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        bits_left <= CNT_W'(CHAIN_LEN);
                        state     <= FETCH;
                    end
                    FETCH: if (cfg_hs) begin
                        shreg <= cfg_data;
                        cap   <= '0;
                        k     <= '0;
                        nbits <= (32'(bits_left) >= 32'(WORD_W)) ? KW'(WORD_W) : KW'(bits_left);
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        shreg     <= shreg >> 1;
                        cap       <= cap_nxt;
                        k         <= k + KW'(1);
                        bits_left <= bits_left - CNT_W'(1);
                        if (last_bit) begin
                            rd_data  <= cap_nxt;
                            rd_valid <= 1'b1;
                            state    <= (bits_left == CNT_W'(1)) ? DRAIN : FETCH;
                        end
                    end
                    DRAIN: if (rd_hs) state <= DONE;
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench with DFF chain models and a readback scoreboard
module tb_ccff_chain_loader;
    localparam int W  = 8;
    localparam int L  = 16;
    localparam int L3 = 3;
    logic prog_clk = 1'b0, prog_reset = 1'b0;
    logic start = 1'b0, abort = 1'b0, cfg_valid = 1'b0, rd_ready = 1'b1;
    logic [W-1:0] cfg_data = '0;
    logic busy, done, aborted, cfg_ready, rd_valid, ccff_head, ccff_tail, prog_clk_en;
    logic [W-1:0] rd_data;
    logic [4:0] bits_left;
    logic [L-1:0] mem, pre_val, ref_chain, abort_base;
    logic pre = 1'b0;
    logic p_start = 1'b0, p_cfg_valid = 1'b0, p_rd_ready = 1'b1;
    logic [W-1:0] p_cfg_data = '0;
    logic p_busy, p_done, p_aborted, p_cfg_ready, p_rd_valid, p_head, p_tail, p_en;
    logic [W-1:0] p_rd_data, p_rd;
    logic [1:0] p_bits_left;
    logic [L3-1:0] mem3, pre3;
    logic [W-1:0] cfg_q[$], exp_q[$];
    logic [W-1:0] aw;
    int checks, passed, cyc, en_cnt, hs_cnt, done_cyc, remaining, bad;
    int p_hs, p_en_cnt, p_rd_n, p_done_cyc;
    logic starve = 1'b0;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en), .bits_left(bits_left));

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L3)) dut3 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(p_start), .abort(1'b0),
        .busy(p_busy), .done(p_done), .aborted(p_aborted), .cfg_data(p_cfg_data),
        .cfg_valid(p_cfg_valid), .cfg_ready(p_cfg_ready), .rd_data(p_rd_data),
        .rd_valid(p_rd_valid), .rd_ready(p_rd_ready), .ccff_head(p_head),
        .ccff_tail(p_tail), .prog_clk_en(p_en), .bits_left(p_bits_left));

    always #5 prog_clk = ~prog_clk;

    // gated DFF chains: head enters position 0, tail leaves the last position
    always @(posedge prog_clk) if (pre) mem <= pre_val; else if (prog_clk_en) mem <= {mem[L-2:0], ccff_head};
    always @(posedge prog_clk) if (pre) mem3 <= pre3; else if (p_en) mem3 <= {mem3[L3-2:0], p_head};
    assign ccff_tail = mem[L-1];
    assign p_tail    = mem3[L3-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        logic [W-1:0] rb;
        int n;
        rb = '0;
        n = remaining < W ? remaining : W;
        for (int b = 0; b < n; b++) begin
            rb[b] = ref_chain[L-1];
            ref_chain = {ref_chain[L-2:0], w[b]};
        end
        remaining -= n;
        cfg_q.push_back(w);
        exp_q.push_back(rb);
    endtask

    task automatic new_load(input logic [W-1:0] w0, input logic [W-1:0] w1);
        remaining = L;
        push_word(w0);
        push_word(w1);
    endtask

    task automatic step;
        logic hs;
        @(negedge prog_clk);
        hs = cfg_valid && cfg_ready;
        if (prog_clk_en) en_cnt++;
        if (hs) hs_cnt++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) chk("rd_extra", 32'(exp_q.size()), 32'd1);
            else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        @(posedge prog_clk);
        #1;
        cyc++;
        if (hs) void'(cfg_q.pop_front());
        cfg_valid = cfg_q.size() > 0 && !starve;
        cfg_data  = cfg_q.size() > 0 ? cfg_q[0] : '0;
    endtask

    task automatic go;
        cyc = 0; en_cnt = 0; hs_cnt = 0; done_cyc = -1;
        cfg_valid = cfg_q.size() > 0 && !starve;
        cfg_data  = cfg_q.size() > 0 ? cfg_q[0] : '0;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 200 && done_cyc < 0; i++) step;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic preload;
        pre_val = 16'hFFFF; pre3 = 3'b110; pre = 1'b1;
        @(posedge prog_clk);
        #1;
        pre = 1'b0;
        ref_chain = 16'hFFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; passed = 0;
        #1 prog_reset = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_en", 32'(prog_clk_en), 32'd0);
        chk("rst_head", 32'(ccff_head), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_bits_left", 32'(bits_left), 32'd0);
        @(posedge prog_clk);
        #1;
        preload;
        prog_reset = 1'b0;

        new_load(8'hA5, 8'h3C);
        go;
        wait_done;
        chk("base_done_cyc", 32'(done_cyc), 32'd20);
        chk("base_en_cycles", 32'(en_cnt), 32'd16);
        chk("base_cfg_hs", 32'(hs_cnt), 32'd2);
        chk("base_m15", 32'(mem[15]), 32'd1);
        chk("base_m8", 32'(mem[8]), 32'd1);
        chk("base_m7", 32'(mem[7]), 32'd0);
        chk("base_m0", 32'(mem[0]), 32'd0);
        chk("base_chain", 32'(mem), 32'h0000A53C);
        chk("base_rd_all", 32'(exp_q.size()), 32'd0);
        chk("base_bits_left", 32'(bits_left), 32'd0);

        new_load(8'hA5, 8'h3C);
        go;
        for (int i = 0; i < 40 && !rd_valid; i++) step;
        rd_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (cfg_ready || prog_clk_en || bits_left != 5'd8) bad++;
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        wait_done;
        chk("stall_chain", 32'(mem), 32'h0000A53C);
        chk("stall_chain_ref", 32'(mem), 32'(ref_chain));
        chk("stall_en_cycles", 32'(en_cnt), 32'd16);

        new_load(8'h0F, 8'hF0);
        go;
        for (int i = 0; i < 10 && cfg_q.size() != 1; i++) step;
        starve = 1'b1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 20 && !(busy && !prog_clk_en && bits_left == 5'd8); i++) step;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step;
            if (prog_clk_en || bits_left != 5'd8 || !busy || !cfg_ready) bad++;
        end
        chk("starve_hold", 32'(bad), 32'd0);
        starve = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = cfg_q[0];
        wait_done;
        chk("starve_chain", 32'(mem), 32'h0000F00F);
        chk("starve_chain_ref", 32'(mem), 32'(ref_chain));
        chk("starve_en_cycles", 32'(en_cnt), 32'd16);

        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("idle_abort_pulse", 32'(aborted), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        abort_base = ref_chain;
        aw = 8'h6B;
        new_load(aw, 8'h11);
        go;
        for (int i = 0; i < 10 && !prog_clk_en; i++) step;
        step; step; step;
        abort = 1'b1;
        #1;
        chk("abort_en_mask", 32'(prog_clk_en), 32'd0);
        step;
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bits_left", 32'(bits_left), 32'd0);
        step;
        chk("abort_pulse_end", 32'(aborted), 32'd0);
        chk("abort_shifts", 32'(en_cnt), 32'd3);
        chk("abort_chain", 32'(mem), 32'({abort_base[12:0], aw[0], aw[1], aw[2]}));
        cfg_q.delete(); exp_q.delete(); cfg_valid = 1'b0;

        new_load(8'h12, 8'h34);
        go;
        for (int i = 0; i < 10 && !prog_clk_en; i++) step;
        step; step;
        #2 prog_reset = 1'b1;
        #1;
        chk("areset_en", 32'(prog_clk_en), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_rd_valid", 32'(rd_valid), 32'd0);
        chk("areset_bits_left", 32'(bits_left), 32'd0);
        @(posedge prog_clk);
        #2 prog_reset = 1'b0;
        cfg_q.delete(); exp_q.delete(); cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        preload;
        new_load(8'h5A, 8'hC3);
        go;
        wait_done;
        chk("reload_done_cyc", 32'(done_cyc), 32'd20);
        chk("reload_en_cycles", 32'(en_cnt), 32'd16);
        chk("reload_chain", 32'(mem), 32'h00005AC3);
        chk("reload_rd_all", 32'(exp_q.size()), 32'd0);

        p_hs = 0; p_en_cnt = 0; p_rd_n = 0; p_done_cyc = -1; p_rd = '0;
        p_cfg_data = 8'h05; p_cfg_valid = 1'b1; p_start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge prog_clk);
            if (p_cfg_valid && p_cfg_ready) p_hs++;
            if (p_en) p_en_cnt++;
            if (p_rd_valid && p_rd_ready) begin p_rd = p_rd_data; p_rd_n++; end
            if (p_done && p_done_cyc < 0) p_done_cyc = c;
            @(posedge prog_clk);
            #1;
            p_start = 1'b0;
        end
        p_cfg_valid = 1'b0;
        chk("part_cfg_hs", 32'(p_hs), 32'd1);
        chk("part_en_cycles", 32'(p_en_cnt), 32'd3);
        chk("part_rd_count", 32'(p_rd_n), 32'd1);
        chk("part_rd_data", 32'(p_rd), 32'h03);
        chk("part_rd_upper", 32'(p_rd[W-1:3]), 32'd0);
        chk("part_m2", 32'(mem3[2]), 32'd1);
        chk("part_m1", 32'(mem3[1]), 32'd0);
        chk("part_m0", 32'(mem3[0]), 32'd1);
        chk("part_done_cyc", 32'(p_done_cyc), 32'd6);
        chk("part_idle", 32'({p_busy, p_aborted, p_bits_left}), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
Configuration-chain controller. Takes bitstream words from a host over a valid/ready stream and serialises them LSB-first onto the ccff_head of a DFF configuration chain of parameterised length. At the same time it captures the bits leaving ccff_tail and returns them as readback words. It gates chain shifting through prog_clk_en, which drives the chain's clock gate, so the chain advances only on controller-issued shift cycles.

Parameters:
WORD_W, 8, width of bitstream and readback words
CHAIN_LEN, 16, number of DFFs in the attached chain (≥1)
CNT_W, $clog2(CHAIN_LEN+1), width of bit counter

Ports:
prog_clk  in  1  the block's single clock; the chain's gated clock is derived from it
prog_reset  in  1  asynchronous, active-high reset
start  in  1  begin a load; sampled only in IDLE
abort  in  1  cancel the load in progress; highest priority after reset
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a load completes
aborted  out  1  one-cycle pulse when an abort is taken
cfg_data  in  WORD_W  bitstream word; bit 0 is shifted first
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  controller accepts cfg_data
rd_data  out  WORD_W  readback word; bit 0 is the first bit out of the chain
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
ccff_head  out  1  serial data to the chain head
ccff_tail  in  1  serial data from the chain tail
prog_clk_en  out  1  chain shifts on the prog_clk rising edge in any cycle where this is high
bits_left  out  CNT_W  chain bits not yet shifted in this load

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, done, aborted, cfg_ready, rd_valid, prog_clk_en, ccff_head = 0.
  - rd_data = 0; bits_left = 0.
- States: IDLE, FETCH, SHIFT, DRAIN, DONE.
- IDLE:
  - On start=1, load bits_left = CHAIN_LEN and go to FETCH. Otherwise stay.
  - cfg_valid is ignored in IDLE.
- FETCH:
  - cfg_ready = (!rd_valid || rd_ready).
  - On a cfg_valid && cfg_ready handshake:
    - latch cfg_data into the shift register;
    - set nbits = min(WORD_W, bits_left);
    - go to SHIFT.
- SHIFT, one bit per cycle:
  - prog_clk_en = 1 and ccff_head = shreg[0].
  - At each edge: shift shreg right by 1; shift ccff_tail into the capture register at index k (k = bit index within the word); decrement bits_left.
  - After nbits cycles:
    - load the capture register into rd_data, with upper WORD_W−nbits bits zero, and set rd_valid = 1;
    - if bits_left = 0 go to DRAIN, else go to FETCH.
- DRAIN: wait until rd_valid && rd_ready, then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- rd_valid clears on rd_valid && rd_ready in any state.
- prog_clk_en is 0 in every state except SHIFT. The chain never shifts outside SHIFT.
- Bit placement after a complete load: with global shift index i = 0..CHAIN_LEN−1 in issue order, bit i lands in chain position CHAIN_LEN−1−i. The first bit shifted ends in the last DFF.
- Partial last word: when CHAIN_LEN mod WORD_W ≠ 0, the final word uses only its low bits and its upper bits are discarded. Surplus words are never requested.
- Timing with all handshakes immediate: load time = 1 + ceil(CHAIN_LEN/WORD_W)·1 + CHAIN_LEN + 2 cycles from start accepted to the done pulse.
- abort:
  - in any state ≠ IDLE: next state IDLE, prog_clk_en = 0 in the same cycle (combinational mask), rd_valid cleared, aborted pulses for one cycle, bits_left = 0;
  - the chain contents are left partially shifted;
  - abort in IDLE does nothing.
- start while busy: ignored.
- Reset mid-load: all outputs return to reset values immediately; chain contents are undefined.

Test Plan:
- Baseline load, no backpressure.
  - Setup: CHAIN_LEN=16, WORD_W=8; 16-DFF chain model preloaded 0xFFFF; send 0xA5 then 0x3C.
  - Required: chain mem_out[15..8] = 0xA5 bit-reversed per placement rule, i.e. mem_out[15]=1, mem_out[8]=1; mem_out[7]=0 (0x3C bit0), mem_out[0]=0.
  - Required: rd_data sequence 0xFF, 0xFF; done at cycle 20 after start; prog_clk_en high exactly 16 cycles.
- Partial word.
  - Setup: CHAIN_LEN=3, single word 0x05.
  - Required: mem_out[2]=1, mem_out[1]=0, mem_out[0]=1; prog_clk_en high 3 cycles; rd_data upper 5 bits = 0; only one cfg handshake.
- Readback stall.
  - Setup: CHAIN_LEN=16; rd_ready held 0 for 10 cycles after the first rd_valid.
  - Required: cfg_ready=0 and prog_clk_en=0 throughout the stall; load resumes without bit loss; final chain matches the baseline.
- cfg starvation.
  - Setup: cfg_valid low 5 cycles mid-load.
  - Required: FETCH held, prog_clk_en=0, bits_left frozen at 8.
- Abort.
  - Setup: assert abort on the 4th SHIFT cycle.
  - Required: prog_clk_en=0 that cycle; aborted pulse; busy=0 next cycle; exactly 3 chain shifts occurred.
- Async reset.
  - Setup: assert prog_reset mid-SHIFT between edges.
  - Required: prog_clk_en, busy, rd_valid fall immediately; next start performs a clean full load.
